tl_width_splitter: RTL and testbench

TL_WIDTH_SPLITTER -- requirements
Module: tl_width_splitter

---
 rtl/tl_width_splitter.sv | 128 ++++++++++++
 tb/tb_tl_width_splitter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_width_splitter.sv
// tl_width_splitter: narrows a TileLink A channel into OUT_BYTES slices and merges narrow D beats back to IN_BYTES.
module tl_width_splitter #(
  parameter int IN_BYTES = 8,
  parameter int OUT_BYTES = 4,
  parameter int ADDR_BITS = 29,
  parameter int SOURCE_BITS = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     auto_in_a_valid,
  output logic                     auto_in_a_ready,
  input  logic [2:0]               auto_in_a_bits_opcode,
  input  logic [2:0]               auto_in_a_bits_param,
  input  logic [2:0]               auto_in_a_bits_size,
  input  logic [SOURCE_BITS-1:0]   auto_in_a_bits_source,
  input  logic [ADDR_BITS-1:0]     auto_in_a_bits_address,
  input  logic [IN_BYTES-1:0]      auto_in_a_bits_mask,
  input  logic [8*IN_BYTES-1:0]    auto_in_a_bits_data,
  input  logic                     auto_in_a_bits_corrupt,
  output logic                     auto_in_d_valid,
  input  logic                     auto_in_d_ready,
  output logic [2:0]               auto_in_d_bits_opcode,
  output logic [1:0]               auto_in_d_bits_param,
  output logic [2:0]               auto_in_d_bits_size,
  output logic [SOURCE_BITS-1:0]   auto_in_d_bits_source,
  output logic                     auto_in_d_bits_sink,
  output logic                     auto_in_d_bits_denied,
  output logic [8*IN_BYTES-1:0]    auto_in_d_bits_data,
  output logic                     auto_in_d_bits_corrupt,
  output logic                     auto_out_a_valid,
  input  logic                     auto_out_a_ready,
  output logic [2:0]               auto_out_a_bits_opcode,
  output logic [2:0]               auto_out_a_bits_param,
  output logic [2:0]               auto_out_a_bits_size,
  output logic [SOURCE_BITS-1:0]   auto_out_a_bits_source,
  output logic [ADDR_BITS-1:0]     auto_out_a_bits_address,
  output logic [OUT_BYTES-1:0]     auto_out_a_bits_mask,
  output logic [8*OUT_BYTES-1:0]   auto_out_a_bits_data,
  output logic                     auto_out_a_bits_corrupt,
  input  logic                     auto_out_d_valid,
  output logic                     auto_out_d_ready,
  input  logic [2:0]               auto_out_d_bits_opcode,
  input  logic [1:0]               auto_out_d_bits_param,
  input  logic [2:0]               auto_out_d_bits_size,
  input  logic [SOURCE_BITS-1:0]   auto_out_d_bits_source,
  input  logic                     auto_out_d_bits_sink,
  input  logic                     auto_out_d_bits_denied,
  input  logic [8*OUT_BYTES-1:0]   auto_out_d_bits_data,
  input  logic                     auto_out_d_bits_corrupt
);
  localparam int R = IN_BYTES / OUT_BYTES;
  localparam int LO = $clog2(OUT_BYTES);
  localparam int LI = $clog2(IN_BYTES);
  localparam int CW = R > 1 ? LI - LO : 1;
  localparam int W = 8 * OUT_BYTES;
  assign auto_out_a_valid = auto_in_a_valid & ~reset;
  assign auto_out_a_bits_opcode = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param = auto_in_a_bits_param;
  assign auto_out_a_bits_size = auto_in_a_bits_size;
  assign auto_out_a_bits_source = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;
  assign auto_in_d_bits_opcode = auto_out_d_bits_opcode;
  assign auto_in_d_bits_param = auto_out_d_bits_param;
  assign auto_in_d_bits_size = auto_out_d_bits_size;
  assign auto_in_d_bits_source = auto_out_d_bits_source;
  assign auto_in_d_bits_sink = auto_out_d_bits_sink;
  generate
    if (R == 1) begin : g_wire
      assign auto_in_a_ready = auto_out_a_ready & ~reset;
      assign auto_out_a_bits_mask = auto_in_a_bits_mask;
      assign auto_out_a_bits_data = auto_in_a_bits_data;
      assign auto_out_d_ready = auto_in_d_ready & ~reset;
      assign auto_in_d_valid = auto_out_d_valid & ~reset;
      assign auto_in_d_bits_data = auto_out_d_bits_data;
      assign auto_in_d_bits_denied = auto_out_d_bits_denied;
      assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt;
    end else begin : g_split
      logic [CW-1:0] a_cnt, d_cnt, a_n1, d_n1, a_sel;
      logic a_split, a_last, d_merge, d_last, den_acc, cor_acc;
      logic [R-1:0][W-1:0] d_buf;
      // beats-per-group minus one, as a low-bit mask: min(R, 2^size/OUT_BYTES) - 1
      function automatic logic [CW-1:0] span_mask(input logic [2:0] size);
        int k;
        k = int'(size) - LO;
        return k <= 0 ? '0 : k >= CW ? '1 : CW'((1 << k) - 1);
      endfunction
      always_comb begin
        a_split = ~auto_in_a_bits_opcode[2] && auto_in_a_bits_size > 3'(LO);
        a_n1 = a_split ? span_mask(auto_in_a_bits_size) : '0;
        a_sel = (auto_in_a_bits_address[LI-1:LO] & ~a_n1) | a_cnt;
        a_last = a_cnt == a_n1;
        d_merge = (auto_out_d_bits_opcode == 3'd1 || auto_out_d_bits_opcode == 3'd5) &&
                  auto_out_d_bits_size > 3'(LO);
        d_n1 = d_merge ? span_mask(auto_out_d_bits_size) : '0;
        d_last = d_cnt == d_n1;
        auto_in_d_bits_data = '0;
        for (int i = 0; i < R; i++)
          auto_in_d_bits_data[i*W +: W] = (CW'(i) & d_n1) == d_n1 ? auto_out_d_bits_data : d_buf[CW'(i) & d_n1];
      end
      assign auto_in_a_ready = auto_out_a_ready & a_last & ~reset;
      assign auto_out_a_bits_mask = auto_in_a_bits_mask[a_sel*OUT_BYTES +: OUT_BYTES];
      assign auto_out_a_bits_data = auto_in_a_bits_data[a_sel*W +: W];
      assign auto_out_d_ready = ~reset & (d_last ? auto_in_d_ready : 1'b1);
      assign auto_in_d_valid = ~reset & auto_out_d_valid & d_last;
      assign auto_in_d_bits_denied = auto_out_d_bits_denied | den_acc;
      assign auto_in_d_bits_corrupt = auto_out_d_bits_corrupt | cor_acc;
      always_ff @(posedge clock) begin
        if (reset) begin
          a_cnt <= '0;
          d_cnt <= '0;
          den_acc <= 1'b0;
          cor_acc <= 1'b0;
        end else begin
          if (auto_out_a_valid && auto_out_a_ready)
            a_cnt <= a_last ? '0 : a_cnt + CW'(1);
          if (auto_out_d_valid && auto_out_d_ready) begin
            d_cnt <= d_last ? '0 : d_cnt + CW'(1);
            den_acc <= d_last ? 1'b0 : den_acc | auto_out_d_bits_denied;
            cor_acc <= d_last ? 1'b0 : cor_acc | auto_out_d_bits_corrupt;
          end
        end
      end
      always_ff @(posedge clock)
        if (auto_out_d_valid && auto_out_d_ready && !d_last) d_buf[d_cnt] <= auto_out_d_bits_data;
    end
  endgenerate
endmodule

// File: tb/tb_tl_width_splitter.sv
// tb_tl_width_splitter: directed vector bench for the 8-to-4 byte TileLink width splitter.
module tb_tl_width_splitter;
  logic clock = 0, reset = 1;
  logic auto_in_a_valid, auto_in_a_ready;
  logic [2:0] auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size;
  logic [5:0] auto_in_a_bits_source;
  logic [28:0] auto_in_a_bits_address;
  logic [7:0] auto_in_a_bits_mask;
  logic [63:0] auto_in_a_bits_data;
  logic auto_in_a_bits_corrupt;
  logic auto_in_d_valid, auto_in_d_ready;
  logic [2:0] auto_in_d_bits_opcode, auto_in_d_bits_size;
  logic [1:0] auto_in_d_bits_param;
  logic [5:0] auto_in_d_bits_source;
  logic auto_in_d_bits_sink, auto_in_d_bits_denied, auto_in_d_bits_corrupt;
  logic [63:0] auto_in_d_bits_data;
  logic auto_out_a_valid, auto_out_a_ready;
  logic [2:0] auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size;
  logic [5:0] auto_out_a_bits_source;
  logic [28:0] auto_out_a_bits_address;
  logic [3:0] auto_out_a_bits_mask;
  logic [31:0] auto_out_a_bits_data;
  logic auto_out_a_bits_corrupt;
  logic auto_out_d_valid, auto_out_d_ready;
  logic [2:0] auto_out_d_bits_opcode, auto_out_d_bits_size;
  logic [1:0] auto_out_d_bits_param;
  logic [5:0] auto_out_d_bits_source;
  logic auto_out_d_bits_sink, auto_out_d_bits_denied, auto_out_d_bits_corrupt;
  logic [31:0] auto_out_d_bits_data;
  int total = 0, bad = 0, acc_a = 0, a0;

  tl_width_splitter dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(auto_in_a_valid), .auto_in_a_ready(auto_in_a_ready),
    .auto_in_a_bits_opcode(auto_in_a_bits_opcode), .auto_in_a_bits_param(auto_in_a_bits_param),
    .auto_in_a_bits_size(auto_in_a_bits_size), .auto_in_a_bits_source(auto_in_a_bits_source),
    .auto_in_a_bits_address(auto_in_a_bits_address), .auto_in_a_bits_mask(auto_in_a_bits_mask),
    .auto_in_a_bits_data(auto_in_a_bits_data), .auto_in_a_bits_corrupt(auto_in_a_bits_corrupt),
    .auto_in_d_valid(auto_in_d_valid), .auto_in_d_ready(auto_in_d_ready),
    .auto_in_d_bits_opcode(auto_in_d_bits_opcode), .auto_in_d_bits_param(auto_in_d_bits_param),
    .auto_in_d_bits_size(auto_in_d_bits_size), .auto_in_d_bits_source(auto_in_d_bits_source),
    .auto_in_d_bits_sink(auto_in_d_bits_sink), .auto_in_d_bits_denied(auto_in_d_bits_denied),
    .auto_in_d_bits_data(auto_in_d_bits_data), .auto_in_d_bits_corrupt(auto_in_d_bits_corrupt),
    .auto_out_a_valid(auto_out_a_valid), .auto_out_a_ready(auto_out_a_ready),
    .auto_out_a_bits_opcode(auto_out_a_bits_opcode), .auto_out_a_bits_param(auto_out_a_bits_param),
    .auto_out_a_bits_size(auto_out_a_bits_size), .auto_out_a_bits_source(auto_out_a_bits_source),
    .auto_out_a_bits_address(auto_out_a_bits_address), .auto_out_a_bits_mask(auto_out_a_bits_mask),
    .auto_out_a_bits_data(auto_out_a_bits_data), .auto_out_a_bits_corrupt(auto_out_a_bits_corrupt),
    .auto_out_d_valid(auto_out_d_valid), .auto_out_d_ready(auto_out_d_ready),
    .auto_out_d_bits_opcode(auto_out_d_bits_opcode), .auto_out_d_bits_param(auto_out_d_bits_param),
    .auto_out_d_bits_size(auto_out_d_bits_size), .auto_out_d_bits_source(auto_out_d_bits_source),
    .auto_out_d_bits_sink(auto_out_d_bits_sink), .auto_out_d_bits_denied(auto_out_d_bits_denied),
    .auto_out_d_bits_data(auto_out_d_bits_data), .auto_out_d_bits_corrupt(auto_out_d_bits_corrupt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) if (auto_in_a_valid && auto_in_a_ready) acc_a++;

  typedef struct {
    logic [2:0] op, sz; logic [28:0] addr; logic [7:0] mask; logic [63:0] data; logic rdy;
    logic [3:0] emask; logic [31:0] edata; logic eready;
  } a_vec_t;
  typedef struct {
    logic [2:0] op, sz; logic [31:0] data; logic den, cor, rdy;
    logic evalid, eoready, chk; logic [63:0] edata; logic eden, ecor;
  } d_vec_t;
  a_vec_t av[8];
  d_vec_t dv[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] sz, input logic [28:0] addr,
                         input logic [7:0] mask, input logic [63:0] data);
    auto_in_a_valid = 1; auto_in_a_bits_opcode = op; auto_in_a_bits_size = sz;
    auto_in_a_bits_address = addr; auto_in_a_bits_mask = mask; auto_in_a_bits_data = data;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] data,
                         input logic den, input logic cor);
    auto_out_d_valid = 1; auto_out_d_bits_opcode = op; auto_out_d_bits_size = sz;
    auto_out_d_bits_data = data; auto_out_d_bits_denied = den; auto_out_d_bits_corrupt = cor;
  endtask

  initial begin
    av[0] = '{3'd0, 3'd3, 29'h1000, 8'hFF, 64'h1122334455667788, 1'b1, 4'hF, 32'h55667788, 1'b0};
    av[1] = '{3'd4, 3'd2, 29'h1004, 8'hF0, 64'h0, 1'b1, 4'hF, 32'h0, 1'b1};
    av[2] = '{3'd4, 3'd2, 29'h1000, 8'h0F, 64'hCAFEF00D12345678, 1'b1, 4'hF, 32'h12345678, 1'b1};
    av[3] = '{3'd1, 3'd0, 29'h1005, 8'h20, 64'hAABBCCDD11223344, 1'b1, 4'h2, 32'hAABBCCDD, 1'b1};
    av[4] = '{3'd4, 3'd3, 29'h1000, 8'hFF, 64'h1122334455667788, 1'b1, 4'hF, 32'h55667788, 1'b1};
    av[5] = '{3'd0, 3'd2, 29'h1004, 8'hF0, 64'h9988776600000000, 1'b1, 4'hF, 32'h99887766, 1'b1};
    av[6] = '{3'd2, 3'd3, 29'h1000, 8'hFF, 64'h0102030405060708, 1'b0, 4'hF, 32'h05060708, 1'b0};
    av[7] = '{3'd1, 3'd1, 29'h1006, 8'hC0, 64'h7777666655554444, 1'b1, 4'hC, 32'h77776666, 1'b1};
    dv[0] = '{3'd1, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b0};
    dv[1] = '{3'd0, 3'd3, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1234567812345678, 1'b0, 1'b0};
    dv[2] = '{3'd1, 3'd3, 32'h55667788, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};
    dv[3] = '{3'd5, 3'd3, 32'h55667788, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    dv[4] = '{3'd0, 3'd2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    dv[5] = '{3'd4, 3'd3, 32'hABCD0123, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'hABCD0123ABCD0123, 1'b0, 1'b1};
    dv[6] = '{3'd1, 3'd1, 32'h0000FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0000FFFF0000FFFF, 1'b0, 1'b0};
    auto_in_a_bits_param = 3'd0; auto_in_a_bits_source = 6'h2A; auto_in_a_bits_corrupt = 0;
    auto_out_d_bits_param = 2'd0; auto_out_d_bits_source = 6'h15; auto_out_d_bits_sink = 1;
    auto_out_a_ready = 1; auto_in_d_ready = 1;
    drive_a(3'd0, 3'd3, 29'h1000, 8'hFF, 64'h1122334455667788);
    drive_d(3'd1, 3'd3, 32'h1, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_a_valid", 64'(auto_out_a_valid), 64'h0);
    chk("rst_in_a_ready", 64'(auto_in_a_ready), 64'h0);
    chk("rst_in_d_valid", 64'(auto_in_d_valid), 64'h0);
    chk("rst_out_d_ready", 64'(auto_out_d_ready), 64'h0);
    auto_in_a_valid = 0; auto_out_d_valid = 0;
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      drive_a(av[i].op, av[i].sz, av[i].addr, av[i].mask, av[i].data);
      auto_out_a_ready = av[i].rdy;
      #1;
      chk($sformatf("a%0d_valid", i), 64'(auto_out_a_valid), 64'h1);
      chk($sformatf("a%0d_mask", i), 64'(auto_out_a_bits_mask), 64'(av[i].emask));
      chk($sformatf("a%0d_data", i), 64'(auto_out_a_bits_data), 64'(av[i].edata));
      chk($sformatf("a%0d_ready", i), 64'(auto_in_a_ready), 64'(av[i].eready));
      chk($sformatf("a%0d_fields", i),
          64'({auto_out_a_bits_opcode, auto_out_a_bits_size, auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_corrupt}),
          64'({av[i].op, av[i].sz, 6'h2A, av[i].addr, 1'b0}));
      #1 auto_in_a_valid = 0;
    end
    auto_out_a_ready = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      drive_d(dv[i].op, dv[i].sz, dv[i].data, dv[i].den, dv[i].cor);
      auto_in_d_ready = dv[i].rdy;
      #1;
      chk($sformatf("d%0d_valid", i), 64'(auto_in_d_valid), 64'(dv[i].evalid));
      chk($sformatf("d%0d_oready", i), 64'(auto_out_d_ready), 64'(dv[i].eoready));
      chk($sformatf("d%0d_flags", i), 64'({auto_in_d_bits_denied, auto_in_d_bits_corrupt}), 64'({dv[i].eden, dv[i].ecor}));
      if (dv[i].chk) begin
        chk($sformatf("d%0d_data", i), auto_in_d_bits_data, dv[i].edata);
        chk($sformatf("d%0d_fields", i),
            64'({auto_in_d_bits_opcode, auto_in_d_bits_size, auto_in_d_bits_source, auto_in_d_bits_sink}),
            64'({dv[i].op, dv[i].sz, 6'h15, 1'b1}));
      end
      #1 auto_out_d_valid = 0;
    end
    // split PutFull with a 3-cycle stall on the second slice
    a0 = acc_a;
    @(negedge clock);
    drive_a(3'd0, 3'd3, 29'h1000, 8'hFF, 64'h1122334455667788);
    auto_out_a_ready = 1;
    #1 chk("split_s0_data", 64'(auto_out_a_bits_data), 64'h55667788);
    chk("split_s0_ready", 64'(auto_in_a_ready), 64'h0);
    @(negedge clock);
    auto_out_a_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("stall%0d_data", c), 64'(auto_out_a_bits_data), 64'h11223344);
      chk($sformatf("stall%0d_mask", c), 64'(auto_out_a_bits_mask), 64'hF);
      chk($sformatf("stall%0d_ready", c), 64'(auto_in_a_ready), 64'h0);
      if (c < 2) @(negedge clock);
    end
    @(negedge clock);
    auto_out_a_ready = 1;
    #1 chk("split_s1_data", 64'(auto_out_a_bits_data), 64'h11223344);
    chk("split_s1_ready", 64'(auto_in_a_ready), 64'h1);
    @(negedge clock);
    auto_in_a_valid = 0;
    chk("split_accepts", 64'(acc_a - a0), 64'h1);
    @(negedge clock);
    drive_a(3'd0, 3'd3, 29'h1000, 8'hFF, 64'hA5A5A5A5C3C3C3C3);
    #1 chk("split_wrap_data", 64'(auto_out_a_bits_data), 64'hC3C3C3C3);
    chk("split_wrap_ready", 64'(auto_in_a_ready), 64'h0);
    // A reset mid-burst restarts at slice 0
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    #1 chk("a_rst_slice0", 64'(auto_out_a_bits_data), 64'hC3C3C3C3);
    chk("a_rst_ready", 64'(auto_in_a_ready), 64'h0);
    auto_in_a_valid = 0;
    // D merge with corrupt on the second beat, inner side stalled
    @(negedge clock);
    drive_d(3'd1, 3'd3, 32'h55667788, 1'b0, 1'b0);
    auto_in_d_ready = 0;
    #1 chk("merge_b0_oready", 64'(auto_out_d_ready), 64'h1);
    chk("merge_b0_ivalid", 64'(auto_in_d_valid), 64'h0);
    @(negedge clock);
    drive_d(3'd1, 3'd3, 32'h11223344, 1'b0, 1'b1);
    #1 chk("merge_b1_ivalid", 64'(auto_in_d_valid), 64'h1);
    chk("merge_b1_oready", 64'(auto_out_d_ready), 64'h0);
    chk("merge_b1_data", auto_in_d_bits_data, 64'h1122334455667788);
    chk("merge_b1_corrupt", 64'(auto_in_d_bits_corrupt), 64'h1);
    @(negedge clock);
    auto_in_d_ready = 1;
    #1 chk("merge_b1_oready2", 64'(auto_out_d_ready), 64'h1);
    @(negedge clock);
    drive_d(3'd0, 3'd2, 32'h0, 1'b0, 1'b0);
    #1 chk("merge_clear_cor", 64'(auto_in_d_bits_corrupt), 64'h0);
    chk("merge_clear_valid", 64'(auto_in_d_valid), 64'h1);
    // D reset after a buffered beat discards it and its corrupt flag
    @(negedge clock);
    drive_d(3'd1, 3'd3, 32'h99999999, 1'b1, 1'b1);
    @(negedge clock);
    auto_out_d_valid = 0;
    reset = 1;
    @(negedge clock);
    reset = 0;
    drive_d(3'd1, 3'd3, 32'hAAAA0000, 1'b0, 1'b0);
    #1 chk("d_rst_b0_ivalid", 64'(auto_in_d_valid), 64'h0);
    @(negedge clock);
    drive_d(3'd1, 3'd3, 32'hBBBB1111, 1'b0, 1'b0);
    #1 chk("d_rst_b1_ivalid", 64'(auto_in_d_valid), 64'h1);
    chk("d_rst_b1_data", auto_in_d_bits_data, 64'hBBBB1111AAAA0000);
    chk("d_rst_b1_flags", 64'({auto_in_d_bits_denied, auto_in_d_bits_corrupt}), 64'h0);
    @(negedge clock);
    auto_out_d_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
